mcpu6_core: RTL and testbench
=============================

// Module: mcpu6_core
// PURPOSE
//  Parametrised accumulator CPU core; next generation of the 6-bit-opcode tiny CPU.
//  Fetches one instruction per accepted clock from an external stream (inst_in/inst_valid).
//  Executes on a DATA_W accumulator with carry, a NREGS register file and a PC_W program counter.
//  Drives PC, accumulator and a latched OUT port to the tile top, which muxes them onto pins.
// PARAMETERS
//  DATA_W  8  accumulator/register width; >=8, multiple of 4
//  PC_W    8  program counter width; >=4
//  NREGS   8  register file depth; power of 2, 2..8; index = inst_in[$clog2(NREGS)-1:0]
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       reset, synchronous, active-high
//  inst_in     in   6       instruction opcode
//  inst_valid  in   1       1 = execute inst_in this cycle; 0 = hold all state
//  pc_o        out  PC_W    program counter
//  accu_o      out  DATA_W  accumulator
//  carry_o     out  1       carry flag
//  out_o       out  DATA_W  output latch, loaded by OUT
//  out_stb     out  1       1-cycle pulse, cycle after OUT executes
// BEHAVIOUR
//  Reset: pc_o=0, accu_o=0, carry_o=0, out_o=0, out_stb=0, iflag=0, link=0, all regs=0.
//  inst_valid=0: pc, accu, carry, iflag, regs, link, out_o hold; out_stb=0.
//  Every valid instruction takes 1 cycle; results are visible on the next posedge.
//  PC update (priority): BCC taken -> pc+sext(imm4); JMPA -> A[PC_W-1:0]; else pc+1.
//   Arithmetic is modulo 2^PC_W (wrap 255->0 at PC_W=8). A is truncated or zero-extended to PC_W.
//  Opcodes (imm4=inst_in[3:0], r=reg index):
//   00iiii BCC: taken iff carry=0; carry<=0 always.
//   01iiii LDI: if iflag=0, A<=sext(imm4); else A<={A[DATA_W-5:0],imm4}.
//    Chained LDIs build a constant MS nibble first.
//   100rrr ADD: {C,A}<=A+reg[r], carry is bit DATA_W of the sum.
//   101rrr STA: reg[r]<=A on posedge; register file is fully synchronous, no latches.
//   110rrr LDA: A<=reg[r]; carry unchanged.
//   111000 NOT: A<=~A.
//   111001 OUT: out_o<=A; out_stb=1 next cycle.
//   111010 JMPA: pc<=A.
//   111011 RRC: {A,C}<={C,A} (rotate right through carry).
//   11110x: link ops, see CONFIGURATION. 11111x: NOP.
//  Register index bits above $clog2(NREGS) are ignored, so indices alias.
//  iflag<=1 after a valid LDI and 0 after any other valid opcode; iflag holds while inst_valid=0.
//  STA then LDA of the same r in consecutive cycles returns the new value.
//  rst has priority over inst_valid. A reset mid-stream discards the current instruction.
// CONFIGURATION
//  MCPU6_LINK_EN defined:
//   111100 JAL: link<=pc+1, pc<=A.
//   111101 RET: pc<=link. link is a single PC_W register; nesting overwrites it.
//  MCPU6_LINK_EN undefined: 11110x execute as NOP (pc+1), and no link register is built.
// STRUCTURE
//  mcpu6_pkg: opcode localparams (OP_BCC, OP_LDI, OP_ADD, OP_STA, OP_LDA, OP_NOT,
//   OP_OUT, OP_JMPA, OP_RRC, OP_JAL, OP_RET) and the sext4 function.
//  Sub-module mcpu6_regfile #(DATA_W,NREGS): 1 sync write port, 1 async read port, sync clear.
//  Decode, ALU, PC, flags and the OUT latch live in mcpu6_core.
// TESTING
//  Reset, then LDI 0x7, LDI 0x3 -> accu_o=0x73, pc_o=2.
//  accu=0xF0; STA r1; LDI 0x1, LDI 0x0 (A=0x10); ADD r1 -> accu_o=0x00, carry_o=1.
//   Then BCC +3 -> not taken, pc+1, carry_o=0; BCC -2 -> taken, pc-=2.
//  accu=0x81, carry=0; RRC -> accu_o=0x40, carry_o=1; OUT -> out_o=0x40, out_stb high one cycle.
//  inst_valid=0 for 3 cycles mid-program -> all outputs frozen, out_stb=0; resume identical.
//  pc=0xFF, NOP -> pc_o=0x00; accu=0x25, JMPA -> pc_o=0x25.
//  MCPU6_LINK_EN: at pc=0x10 with A=0x40, JAL -> pc=0x40; RET -> pc=0x11.
//   Without the macro, JAL -> pc=0x11.

Source files
------------

// File: rtl/mcpu6_pkg.sv
// mcpu6_pkg: opcode encodings and the 4-bit sign-extension helper for the mcpu6 core.
package mcpu6_pkg;

    localparam logic [1:0] OP_BCC  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_STA  = 3'b101;
    localparam logic [2:0] OP_LDA  = 3'b110;
    localparam logic [5:0] OP_NOT  = 6'b111000;
    localparam logic [5:0] OP_OUT  = 6'b111001;
    localparam logic [5:0] OP_JMPA = 6'b111010;
    localparam logic [5:0] OP_RRC  = 6'b111011;
    localparam logic [5:0] OP_JAL  = 6'b111100;
    localparam logic [5:0] OP_RET  = 6'b111101;

    // Callers cast the 64-bit result down to their own width.
    function automatic logic [63:0] sext4(input logic [3:0] v);
        return {{60{v[3]}}, v};
    endfunction

endpackage

// File: rtl/mcpu6_regfile.sv
// mcpu6_regfile: NREGS x DATA_W register file, one sync write port, one async read port, sync clear.
module mcpu6_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NREGS];

    // Clear every entry on reset, otherwise write one entry when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/mcpu6_core.sv
// mcpu6_core: accumulator CPU core; optional JAL/RET link register enabled by MCPU6_LINK_EN.
module mcpu6_core
    import mcpu6_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        inst_in,
    input  logic              inst_valid,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] accu_o,
    output logic              carry_o,
    output logic [DATA_W-1:0] out_o,
    output logic              out_stb
);

    localparam int AW = $clog2(NREGS);

    logic              iflag, iflag_n, carry_n, we;
    logic [PC_W-1:0]   pc_n, pc_inc, a_pc;
    logic [DATA_W-1:0] accu_n, out_n, rdata;
    logic [DATA_W:0]   sum;
    logic [3:0]        imm;
    logic [AW-1:0]     ridx;
`ifdef MCPU6_LINK_EN
    logic [PC_W-1:0]   link, link_n;
`endif

    assign imm    = inst_in[3:0];
    assign ridx   = inst_in[AW-1:0];
    assign pc_inc = pc_o + PC_W'(1);
    assign a_pc   = PC_W'(accu_o);
    assign sum    = {1'b0, accu_o} + {1'b0, rdata};

    mcpu6_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (ridx),
        .wdata (accu_o),
        .raddr (ridx),
        .rdata (rdata)
    );

    // Decode the current opcode into next-state values for PC, accumulator, flags and OUT latch.
    always_comb begin
        pc_n    = pc_inc;
        accu_n  = accu_o;
        carry_n = carry_o;
        out_n   = out_o;
        iflag_n = 1'b0;
        we      = 1'b0;
`ifdef MCPU6_LINK_EN
        link_n  = link;
`endif
        if (inst_in[5:4] == OP_BCC) begin
            carry_n = 1'b0;
            pc_n    = carry_o ? pc_inc : pc_o + PC_W'(sext4(imm));
        end else if (inst_in[5:4] == OP_LDI) begin
            iflag_n = 1'b1;
            accu_n  = iflag ? {accu_o[DATA_W-5:0], imm} : DATA_W'(sext4(imm));
        end else if (inst_in[5:3] == OP_ADD) begin
            {carry_n, accu_n} = sum;
        end else if (inst_in[5:3] == OP_STA) begin
            we = inst_valid;
        end else if (inst_in[5:3] == OP_LDA) begin
            accu_n = rdata;
        end else begin
            case (inst_in)
                OP_NOT:  accu_n = ~accu_o;
                OP_OUT:  out_n = accu_o;
                OP_JMPA: pc_n = a_pc;
                OP_RRC: begin
                    accu_n  = {carry_o, accu_o[DATA_W-1:1]};
                    carry_n = accu_o[0];
                end
`ifdef MCPU6_LINK_EN
                OP_JAL: begin
                    link_n = pc_inc;
                    pc_n   = a_pc;
                end
                OP_RET:  pc_n = link;
`endif
                default: ;
            endcase
        end
    end

    // Commit architectural state only for valid instructions; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o    <= '0;
            accu_o  <= '0;
            carry_o <= 1'b0;
            out_o   <= '0;
            out_stb <= 1'b0;
            iflag   <= 1'b0;
        end else begin
            out_stb <= inst_valid && inst_in == OP_OUT;
            if (inst_valid) begin
                pc_o    <= pc_n;
                accu_o  <= accu_n;
                carry_o <= carry_n;
                out_o   <= out_n;
                iflag   <= iflag_n;
            end
        end
    end

`ifdef MCPU6_LINK_EN
    // Single-entry link register written by JAL.
    always_ff @(posedge clk) begin
        if (rst) link <= '0;
        else if (inst_valid) link <= link_n;
    end
`endif

endmodule

// File: tb/tb_mcpu6_core.sv
// tb_mcpu6_core: directed vector table plus a hand-written LDI chain sequence for mcpu6_core.
module tb_mcpu6_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] inst_in;
    logic       inst_valid;
    logic [7:0] pc_o, accu_o, out_o;
    logic       carry_o, out_stb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       r;
        logic       v;
        logic [5:0] i;
        logic [7:0] pc;
        logic [7:0] a;
        logic       c;
        logic [7:0] o;
        logic       s;
    } vec_t;

    vec_t tv[$];

`ifdef MCPU6_LINK_EN
    localparam logic [7:0] JAL_PC = 8'h40;
    localparam logic [7:0] RET_PC = 8'h11;
`else
    localparam logic [7:0] JAL_PC = 8'h11;
    localparam logic [7:0] RET_PC = 8'h12;
`endif

    mcpu6_core #(.DATA_W(8), .PC_W(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .pc_o       (pc_o),
        .accu_o     (accu_o),
        .carry_o    (carry_o),
        .out_o      (out_o),
        .out_stb    (out_stb)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [5:0] i, input logic [7:0] pc,
                       input logic [7:0] a, input logic c, input logic [7:0] o, input logic s);
        tv.push_back('{r, v, i, pc, a, c, o, s});
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] i);
        rst = r;
        inst_valid = v;
        inst_in = i;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] pc, input logic [7:0] a,
                         input logic c, input logic [7:0] o, input logic s);
        checks++;
        if (pc_o !== pc || accu_o !== a || carry_o !== c || out_o !== o || out_stb !== s) begin
            errors++;
            $display("FAIL %s: got pc=%h accu=%h c=%b out=%h stb=%b, expected pc=%h accu=%h c=%b out=%h stb=%b",
                     name, pc_o, accu_o, carry_o, out_o, out_stb, pc, a, c, o, s);
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_valid = 1'b0;
        inst_in = 6'h3E;
        //   rst   v    inst    pc     accu   c     out    stb
        add(1'b1, 1'b0, 6'h3E, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h17, 8'h01, 8'h07, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h13, 8'h02, 8'h73, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h3E, 8'h03, 8'h73, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h1F, 8'h04, 8'hFF, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h10, 8'h05, 8'hF0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h29, 8'h06, 8'hF0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h11, 8'h07, 8'h01, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h10, 8'h08, 8'h10, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h21, 8'h09, 8'h00, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h03, 8'h0A, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h0E, 8'h08, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h18, 8'h09, 8'hF8, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h11, 8'h0A, 8'h81, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h3B, 8'h0B, 8'h40, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h39, 8'h0C, 8'h40, 1'b1, 8'h40, 1'b1);
        add(1'b0, 1'b0, 6'h39, 8'h0C, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b0, 6'h21, 8'h0C, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b0, 6'h15, 8'h0C, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3E, 8'h0D, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h2B, 8'h0E, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h12, 8'h0F, 8'h02, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h2D, 8'h10, 8'h02, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h38, 8'h11, 8'hFD, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h2E, 8'h12, 8'hFD, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h33, 8'h13, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h36, 8'h14, 8'hFD, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h35, 8'h15, 8'h02, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h26, 8'h16, 8'hFF, 1'b0, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h21, 8'h17, 8'hEF, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h1F, 8'h18, 8'hFF, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3A, 8'hFF, 8'hFF, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3E, 8'h00, 8'hFF, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h12, 8'h01, 8'h02, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h15, 8'h02, 8'h25, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3A, 8'h25, 8'h25, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h11, 8'h26, 8'h01, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h10, 8'h27, 8'h10, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3A, 8'h10, 8'h10, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h33, 8'h11, 8'h40, 1'b1, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h0F, 8'h12, 8'h40, 1'b0, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h0E, 8'h10, 8'h40, 1'b0, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3C, JAL_PC, 8'h40, 1'b0, 8'h40, 1'b0);
        add(1'b0, 1'b1, 6'h3D, RET_PC, 8'h40, 1'b0, 8'h40, 1'b0);
        add(1'b1, 1'b1, 6'h15, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h3E, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h33, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 6'h13, 8'h03, 8'h03, 1'b0, 8'h00, 1'b0);

        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k].r, tv[k].v, tv[k].i);
            check($sformatf("vec%0d", k), tv[k].pc, tv[k].a, tv[k].c, tv[k].o, tv[k].s);
        end

        // Three chained LDIs keep only the last two nibbles in an 8-bit accumulator.
        step(1'b0, 1'b1, 6'h3E);
        step(1'b0, 1'b1, 6'h11);
        step(1'b0, 1'b1, 6'h12);
        step(1'b0, 1'b1, 6'h13);
        check("ldi_chain", 8'h07, 8'h23, 1'b0, 8'h00, 1'b0);

        // OUT strobe is a single-cycle pulse even with a stall right after it.
        step(1'b0, 1'b1, 6'h39);
        check("out_pulse", 8'h08, 8'h23, 1'b0, 8'h23, 1'b1);
        step(1'b0, 1'b0, 6'h39);
        check("out_pulse_end", 8'h08, 8'h23, 1'b0, 8'h23, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
